bs_axi_writer: RTL and testbench

BS_AXI_WRITER -- requirements
Module: bs_axi_writer

---
 rtl/bs_axi_writer.sv | 213 +++++++++++++++++++++
 tb/tb_bs_axi_writer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_axi_writer.sv
// bs_axi_writer
//   Streams 64-bit words from a show-ahead-free FIFO into a ring buffer in
//   memory through a single-outstanding AXI write master.
//   Each burst is first staged locally (up to BURST_LEN words). The address
//   phase, the data phase and the response phase then run one after another.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   buf_base, buf_size         ring base (128-byte aligned) and size in bytes
//   start, flush               begin a frame / drain the remainder and finish
//   busy, done, err            frame active, end-of-frame pulse, sticky BRESP error
//   bytes_written              bytes acknowledged by B since the last start
//   fifo_rdusedw, fifo_rdempty,
//   fifo_rdreq, fifo_q         FIFO read side (q valid one cycle after rdreq)
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4 write master channels
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | choosing the burst length, then reading n words into staging
// AW     | address phase, awvalid held until awready
// W      | data beats from staging, wlast on beat n
// B      | waiting for the write response, advancing the ring pointer
// DONE   | one-cycle done pulse, back to IDLE
module bs_axi_writer #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           buf_base,
    input  logic [31:0]           buf_size,
    input  logic                  start,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           bytes_written,
    input  logic [FIFO_CNT_W-1:0] fifo_rdusedw,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    input  logic [63:0]           fifo_q,
    output logic [31:0]           m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [63:0]           m_axi_wdata,
    output logic [7:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t           state;
    logic [31:0]      wr_ptr;
    logic [CNT_W-1:0] burst_n;
    logic [CNT_W-1:0] rd_left;
    logic [CNT_W-1:0] cap_cnt;
    logic [CNT_W-1:0] beat;
    logic             reading;
    logic             rd_valid;
    logic             flush_pending;
    logic [63:0]      stage [BURST_LEN];

    logic [31:0]      burst_bytes;
    logic [31:0]      next_ptr;
    logic             full_avail;
    logic [CNT_W-1:0] usedw_n;

    assign burst_bytes = 32'(burst_n) << 3;
    assign next_ptr    = wr_ptr + burst_bytes;
    assign full_avail  = 32'(fifo_rdusedw) >= 32'(BURST_LEN);
    // Only used when fewer than BURST_LEN words remain, so it always fits.
    assign usedw_n     = CNT_W'(fifo_rdusedw);

    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 8'hFF;
    assign m_axi_wdata   = m_axi_wvalid ? stage[beat[IDX_W-1:0]] : 64'd0;

    // fifo_q belongs to the rdreq of the previous cycle, hence rd_valid.
    always_ff @(posedge clk) begin
        if (rd_valid) stage[cap_cnt[IDX_W-1:0]] <= fifo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wr_ptr        <= 32'd0;
            burst_n       <= '0;
            rd_left       <= '0;
            cap_cnt       <= '0;
            beat          <= '0;
            reading       <= 1'b0;
            rd_valid      <= 1'b0;
            flush_pending <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            bytes_written <= 32'd0;
            fifo_rdreq    <= 1'b0;
            m_axi_awaddr  <= 32'd0;
            m_axi_awlen   <= 8'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wlast   <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= fifo_rdreq;
            if (flush && state != S_IDLE) flush_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_ptr        <= buf_base;
                        bytes_written <= 32'd0;
                        err           <= 1'b0;
                        flush_pending <= 1'b0;
                        reading       <= 1'b0;
                        busy          <= 1'b1;
                        state         <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!reading) begin
                        if (full_avail) begin
                            burst_n    <= CNT_W'(BURST_LEN);
                            rd_left    <= CNT_W'(BURST_LEN);
                            cap_cnt    <= '0;
                            fifo_rdreq <= 1'b1;
                            reading    <= 1'b1;
                        end else if (flush_pending && fifo_rdempty) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (flush_pending && usedw_n != '0) begin
                            burst_n    <= usedw_n;
                            rd_left    <= usedw_n;
                            cap_cnt    <= '0;
                            fifo_rdreq <= 1'b1;
                            reading    <= 1'b1;
                        end
                    end else begin
                        if (fifo_rdreq) begin
                            rd_left <= rd_left - CNT_W'(1);
                            if (rd_left == CNT_W'(1)) fifo_rdreq <= 1'b0;
                        end
                        if (rd_valid) begin
                            cap_cnt <= cap_cnt + CNT_W'(1);
                            if (cap_cnt == burst_n - CNT_W'(1)) begin
                                reading       <= 1'b0;
                                m_axi_awaddr  <= wr_ptr;
                                m_axi_awlen   <= 8'(burst_n - CNT_W'(1));
                                m_axi_awvalid <= 1'b1;
                                state         <= S_AW;
                            end
                        end
                    end
                end
                S_AW: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wlast   <= (burst_n == CNT_W'(1));
                        beat          <= '0;
                        state         <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi_wvalid && m_axi_wready) begin
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= S_B;
                        end else begin
                            beat        <= beat + CNT_W'(1);
                            m_axi_wlast <= (beat + CNT_W'(2) == burst_n);
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready  <= 1'b0;
                        bytes_written <= bytes_written + burst_bytes;
                        if (m_axi_bresp != 2'b00) err <= 1'b1;
                        // Full bursts tile the ring exactly, so landing on the end means wrap.
                        wr_ptr <= (next_ptr == buf_base + buf_size) ? buf_base : next_ptr;
                        state  <= S_FILL;
                    end
                end
                S_DONE: begin
                    busy          <= 1'b0;
                    flush_pending <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bs_axi_writer.sv
module tb_bs_axi_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] buf_base = 32'd0;
    logic [31:0] buf_size = 32'h1000;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        busy, done, err;
    logic [31:0] bytes_written;
    logic [7:0]  fifo_rdusedw;
    logic        fifo_rdempty;
    logic        fifo_rdreq;
    logic [63:0] fifo_q = 64'd0;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bs_axi_writer #(.BURST_LEN(16), .FIFO_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .buf_base(buf_base), .buf_size(buf_size),
        .start(start), .flush(flush), .busy(busy), .done(done), .err(err),
        .bytes_written(bytes_written), .fifo_rdusedw(fifo_rdusedw),
        .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    // FIFO model: tasks append at fwr, the read side pops at frd.
    logic [63:0] fmem [0:1023];
    int fwr = 0;
    int frd = 0;
    assign fifo_rdusedw = 8'(fwr - frd);
    assign fifo_rdempty = (fwr == frd);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) frd <= fwr;
        else if (fifo_rdreq) begin
            fifo_q <= fmem[frd];
            frd    <= frd + 1;
        end
    end

    // AXI slave + monitor
    int stall = 0;
    int err_b = -1;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, rdreq_cnt = 0, done_cnt = 0, viol_cnt = 0;
    logic [31:0] aw_addr_log [0:63];
    logic [7:0]  aw_len_log  [0:63];
    logic [63:0] w_data_log  [0:1023];
    logic        w_last_log  [0:1023];
    bit          pending_b = 0, aw_stall_q = 0, w_stall_q = 0;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic [63:0] w_data_q;
    logic        w_last_q;

    always @(negedge clk) begin
        m_axi_awready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_bvalid  = pending_b && ((stall == 0) || ($urandom_range(0, 1) == 1));
        m_axi_bresp   = (b_cnt == err_b) ? 2'b10 : 2'b00;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            pending_b  = 0;
            aw_stall_q = 0;
            w_stall_q  = 0;
        end else begin
            if (fifo_rdreq) rdreq_cnt++;
            if (done) done_cnt++;
            if (aw_stall_q && (!m_axi_awvalid || m_axi_awaddr !== aw_addr_q || m_axi_awlen !== aw_len_q))
                viol_cnt++;
            if (w_stall_q && (!m_axi_wvalid || m_axi_wdata !== w_data_q || m_axi_wlast !== w_last_q))
                viol_cnt++;
            if (m_axi_awvalid && m_axi_wvalid) viol_cnt++;
            if ((m_axi_awvalid || m_axi_wvalid) && m_axi_bready) viol_cnt++;
            aw_stall_q = m_axi_awvalid && !m_axi_awready;
            aw_addr_q  = m_axi_awaddr;
            aw_len_q   = m_axi_awlen;
            w_stall_q  = m_axi_wvalid && !m_axi_wready;
            w_data_q   = m_axi_wdata;
            w_last_q   = m_axi_wlast;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_log[aw_cnt] = m_axi_awaddr;
                aw_len_log[aw_cnt]  = m_axi_awlen;
                aw_cnt++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_log[w_cnt] = m_axi_wdata;
                w_last_log[w_cnt] = m_axi_wlast;
                w_cnt++;
                if (m_axi_wlast) pending_b = 1;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_cnt++;
                pending_b = 0;
            end
        end
    end

    task automatic push_words(input int n, input logic [63:0] seed);
        for (int i = 0; i < n; i++) begin
            fmem[fwr] = seed + 64'(i);
            fwr++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    task automatic wait_b(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (b_cnt >= target) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_cnt >= target) begin ok = 1; break; end
        end
    endtask

    task automatic end_frame(output bit ok);
        int d0;
        d0 = done_cnt;
        pulse_flush();
        wait_done(d0 + 1, ok);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, fifo_rdreq, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, err, fifo_rdreq, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready});
        end
        checks++;
        if (bytes_written !== 32'd0 || m_axi_awaddr !== 32'd0 || m_axi_awlen !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: got bytes=%h awaddr=%h awlen=%h want all 0", bytes_written, m_axi_awaddr, m_axi_awlen);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_burst();
        int a0, w0, b0, r0, bad;
        bit ok;
        buf_base = 32'h1000_0000; buf_size = 32'h1000;
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = rdreq_cnt;
        push_words(16, 64'hA5A5_0000_0000_0000);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy); end
        wait_b(b0 + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_b_timeout: got b=%0d want %0d", b_cnt - b0, 1); end
        checks++;
        if (rdreq_cnt - r0 != 16) begin errors++; $display("FAIL full_rdreq: got %0d want 16", rdreq_cnt - r0); end
        checks++;
        if (aw_cnt - a0 != 1 || aw_addr_log[a0] !== 32'h1000_0000 || aw_len_log[a0] !== 8'd15) begin
            errors++;
            $display("FAIL full_aw: got n=%0d addr=%h len=%0d want 1 10000000 15", aw_cnt - a0, aw_addr_log[a0], aw_len_log[a0]);
        end
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (w_data_log[w0 + i] !== 64'hA5A5_0000_0000_0000 + 64'(i) || w_last_log[w0 + i] !== (i == 15)) bad++;
        checks++;
        if (w_cnt - w0 != 16 || bad != 0) begin
            errors++;
            $display("FAIL full_beats: got beats=%0d bad=%0d want 16 0", w_cnt - w0, bad);
        end
        checks++;
        if (bytes_written !== 32'd128) begin errors++; $display("FAIL full_bytes: got %0d want 128", bytes_written); end
        end_frame(ok);
        checks++;
        if (!ok || busy !== 1'b0) begin errors++; $display("FAIL full_end: got done_seen=%0d busy=%b want 1 0", ok, busy); end
    endtask

    task automatic test_wrap();
        int a0, b0;
        bit ok;
        buf_base = 32'h2000_0000; buf_size = 32'd256;
        a0 = aw_cnt; b0 = b_cnt;
        push_words(48, 64'h2222_0000_0000_0000);
        pulse_start();
        wait_b(b0 + 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_b_timeout: got b=%0d want 3", b_cnt - b0); end
        checks++;
        if (aw_addr_log[a0] !== 32'h2000_0000 || aw_addr_log[a0 + 1] !== 32'h2000_0080 || aw_addr_log[a0 + 2] !== 32'h2000_0000) begin
            errors++;
            $display("FAIL wrap_addr: got %h %h %h want 20000000 20000080 20000000",
                     aw_addr_log[a0], aw_addr_log[a0 + 1], aw_addr_log[a0 + 2]);
        end
        checks++;
        if (bytes_written !== 32'd384) begin errors++; $display("FAIL wrap_bytes: got %0d want 384", bytes_written); end
        end_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_end: got no done want done"); end
    endtask

    task automatic test_flush_short();
        int a0, w0, b0, d0, bad;
        bit ok;
        buf_base = 32'h3000_0000; buf_size = 32'h1000;
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        push_words(21, 64'h3333_0000_0000_0000);
        pulse_start();
        wait_b(b0 + 1, ok);
        checks++;
        if (!ok || bytes_written !== 32'd128) begin
            errors++; $display("FAIL short_first: got ok=%0d bytes=%0d want 1 128", ok, bytes_written);
        end
        d0 = done_cnt;
        pulse_flush();
        wait_b(b0 + 2, ok);
        checks++;
        if (!ok || aw_addr_log[a0 + 1] !== 32'h3000_0080 || aw_len_log[a0 + 1] !== 8'd4) begin
            errors++;
            $display("FAIL short_aw: got ok=%0d addr=%h len=%0d want 1 30000080 4", ok, aw_addr_log[a0 + 1], aw_len_log[a0 + 1]);
        end
        bad = 0;
        for (int i = 0; i < 21; i++)
            if (w_data_log[w0 + i] !== 64'h3333_0000_0000_0000 + 64'(i) || w_last_log[w0 + i] !== (i == 15 || i == 20)) bad++;
        checks++;
        if (w_cnt - w0 != 21 || bad != 0) begin
            errors++; $display("FAIL short_beats: got beats=%0d bad=%0d want 21 0", w_cnt - w0, bad);
        end
        wait_done(d0 + 1, ok);
        checks++;
        if (!ok || busy !== 1'b0 || bytes_written !== 32'd168) begin
            errors++; $display("FAIL short_done: got ok=%0d busy=%b bytes=%0d want 1 0 168", ok, busy, bytes_written);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || done !== 1'b0) begin
            errors++; $display("FAIL short_pulse: got cycles=%0d done=%b want 1 0", done_cnt - d0, done);
        end
    endtask

    task automatic test_backpressure();
        int a0, w0, b0, v0, bad;
        bit ok;
        buf_base = 32'h4000_0000; buf_size = 32'h1000;
        a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; v0 = viol_cnt;
        stall = 1;
        push_words(32, 64'h4444_0000_0000_0000);
        pulse_start();
        wait_b(b0 + 2, ok);
        stall = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_b_timeout: got b=%0d want 2", b_cnt - b0); end
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (w_data_log[w0 + i] !== 64'h4444_0000_0000_0000 + 64'(i) || w_last_log[w0 + i] !== (i == 15 || i == 31)) bad++;
        checks++;
        if (w_cnt - w0 != 32 || bad != 0) begin
            errors++; $display("FAIL bp_beats: got beats=%0d bad=%0d want 32 0", w_cnt - w0, bad);
        end
        checks++;
        if (viol_cnt - v0 != 0) begin errors++; $display("FAIL bp_stable: got violations=%0d want 0", viol_cnt - v0); end
        checks++;
        if (aw_addr_log[a0] !== 32'h4000_0000 || aw_addr_log[a0 + 1] !== 32'h4000_0080 || bytes_written !== 32'd256) begin
            errors++;
            $display("FAIL bp_addr: got %h %h bytes=%0d want 40000000 40000080 256", aw_addr_log[a0], aw_addr_log[a0 + 1], bytes_written);
        end
        end_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_end: got no done want done"); end
    endtask

    task automatic test_error();
        int b0;
        bit ok;
        buf_base = 32'h4800_0000; buf_size = 32'h1000;
        b0 = b_cnt;
        err_b = b0;
        push_words(32, 64'h5555_0000_0000_0000);
        pulse_start();
        wait_b(b0 + 2, ok);
        checks++;
        if (!ok || err !== 1'b1 || bytes_written !== 32'd256) begin
            errors++; $display("FAIL err_set: got ok=%0d err=%b bytes=%0d want 1 1 256", ok, err, bytes_written);
        end
        end_frame(ok);
        checks++;
        if (!ok || err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL err_sticky: got ok=%0d err=%b busy=%b want 1 1 0", ok, err, busy);
        end
        err_b = -1;
        pulse_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL err_clear: got err=%b busy=%b want 0 1", err, busy);
        end
        end_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL err_empty_end: got no done want done"); end
    endtask

    task automatic test_reset_mid();
        int a0, w0, b0;
        bit ok;
        buf_base = 32'h5000_0000; buf_size = 32'h1000;
        w0 = w_cnt; b0 = b_cnt;
        push_words(32, 64'h6666_0000_0000_0000);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (w_cnt - w0 >= 22) begin ok = 1; break; end
        end
        checks++;
        if (!ok || b_cnt - b0 != 1) begin
            errors++; $display("FAIL rmid_reach: got ok=%0d b=%0d want 1 1", ok, b_cnt - b0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, fifo_rdreq, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 8'h00 ||
            bytes_written !== 32'd0 || m_axi_awaddr !== 32'd0 || m_axi_awlen !== 8'd0) begin
            errors++;
            $display("FAIL rmid_outputs: got ctrl=%b bytes=%0d awaddr=%h awlen=%0d want all 0",
                     {busy, done, err, fifo_rdreq, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready},
                     bytes_written, m_axi_awaddr, m_axi_awlen);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a0 = aw_cnt; b0 = b_cnt;
        push_words(16, 64'h7777_0000_0000_0000);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (aw_cnt > a0) begin ok = 1; break; end
        end
        checks++;
        if (!ok || aw_addr_log[a0] !== 32'h5000_0000 || bytes_written !== 32'd0) begin
            errors++; $display("FAIL rmid_restart: got ok=%0d addr=%h bytes=%0d want 1 50000000 0", ok, aw_addr_log[a0], bytes_written);
        end
        wait_b(b0 + 1, ok);
        end_frame(ok);
        checks++;
        if (!ok || bytes_written !== 32'd128) begin
            errors++; $display("FAIL rmid_end: got ok=%0d bytes=%0d want 1 128", ok, bytes_written);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_wrap();
        test_flush_short();
        test_backpressure();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
